// File: rtl/scpu_mem_arb.sv
// scpu_mem_arb: CPU/host arbiter for the shared 256x8 sync-read memory with starvation guard and bounded host lock
module scpu_mem_arb #(
    parameter int MAX_WAIT = 4,
    parameter int MAX_LOCK = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_gnt,
    output logic       cpu_rvalid,
    output logic [7:0] cpu_rdata,
    output logic       cpu_stall,
    input  logic       host_req,
    input  logic       host_we,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    input  logic       host_lock,
    output logic       host_gnt,
    output logic       host_rvalid,
    output logic [7:0] host_rdata,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_din,
    output logic       mem_wr,
    input  logic [7:0] mem_dout
);
    typedef enum logic {OPEN, LOCK} state_t;
    state_t     state;
    logic [3:0] starve_cnt;
    logic [7:0] lock_cnt;
    logic       relock_blk;
    logic [1:0] rd_owner;
    logic       host_owns;
    logic       host_turn;
    always_comb begin
        host_owns   = state == LOCK && host_lock;
        host_turn   = host_req && starve_cnt == 4'(MAX_WAIT);
        host_gnt    = !rst && (host_owns ? host_req : (host_turn || (host_req && !cpu_req)));
        cpu_gnt     = !rst && !host_owns && cpu_req && !host_turn;
        cpu_stall   = cpu_req && !cpu_gnt;
        mem_addr    = host_gnt ? host_addr : cpu_addr;
        mem_din     = host_gnt ? host_wdata : cpu_wdata;
        mem_wr      = host_gnt ? host_we : (cpu_gnt && cpu_we);
        cpu_rvalid  = !rst && rd_owner == 2'd1;
        host_rvalid = !rst && rd_owner == 2'd2;
        cpu_rdata   = cpu_rvalid ? mem_dout : 8'd0;
        host_rdata  = host_rvalid ? mem_dout : 8'd0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= OPEN;
            starve_cnt <= 4'd0;
            lock_cnt   <= 8'd0;
            relock_blk <= 1'b0;
            rd_owner   <= 2'd0;
        end else begin
            rd_owner   <= (host_gnt && !host_we) ? 2'd2 : (cpu_gnt && !cpu_we) ? 2'd1 : 2'd0;
            starve_cnt <= (state == LOCK || host_gnt || !host_req) ? 4'd0
                        : starve_cnt + 4'(starve_cnt != 4'(MAX_WAIT));
            if (!host_lock) relock_blk <= 1'b0;
            if (state == OPEN) begin
                if (host_gnt && host_lock && !relock_blk) begin
                    state    <= LOCK;
                    lock_cnt <= 8'd1;
                end
            end else if (!host_lock) begin
                state <= OPEN;
            end else if (lock_cnt == 8'(MAX_LOCK)) begin
                state      <= OPEN;
                relock_blk <= 1'b1;
            end else begin
                lock_cnt <= lock_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_scpu_mem_arb.sv
// tb_scpu_mem_arb: directed and randomized checks of scpu_mem_arb against a cycle-level reference model
module tb_scpu_mem_arb;
    localparam int MAX_WAIT = 4;
    localparam int MAX_LOCK = 16;
    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req, cpu_we, host_req, host_we, host_lock;
    logic [7:0] cpu_addr, cpu_wdata, host_addr, host_wdata;
    logic       cpu_gnt, cpu_rvalid, cpu_stall, host_gnt, host_rvalid, mem_wr;
    logic [7:0] cpu_rdata, host_rdata, mem_addr, mem_din;
    logic [7:0] mem_dout;
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    int n_checks = 0;
    int n_fail = 0;
    // reference model: host waiting time, lock ownership length and the pending read
    int   waited, lock_len, rd_who;
    bit   locked, blocked;
    logic [7:0] rd_val;
    bit   e_cg, e_hg, e_cr, e_hr, e_wr;
    logic [7:0] e_crd, e_hrd, e_addr, e_din;

    scpu_mem_arb #(.MAX_WAIT(MAX_WAIT), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_lock(host_lock), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wr(mem_wr), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    task automatic settle();
        bit owns, turn;
        @(negedge clk);
        owns  = locked && host_lock;
        turn  = host_req && waited >= MAX_WAIT;
        e_hg  = !rst && (owns ? host_req : (turn || (host_req && !cpu_req)));
        e_cg  = !rst && !owns && cpu_req && !turn;
        e_cr  = !rst && rd_who == 1;
        e_hr  = !rst && rd_who == 2;
        e_crd = e_cr ? rd_val : 8'd0;
        e_hrd = e_hr ? rd_val : 8'd0;
        e_wr  = (e_hg && host_we) || (e_cg && cpu_we);
        e_addr = e_hg ? host_addr : cpu_addr;
        e_din  = e_hg ? host_wdata : cpu_wdata;
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            waited = 0; locked = 0; lock_len = 0; blocked = 0; rd_who = 0;
        end else begin
            rd_who = (e_hg && !host_we) ? 2 : (e_cg && !cpu_we) ? 1 : 0;
            rd_val = ref_mem[e_addr];
            if (e_wr) ref_mem[e_addr] = e_din;
            waited = (locked || !host_req || e_hg) ? 0 : (waited < MAX_WAIT ? waited + 1 : waited);
            if (!locked) begin
                if (e_hg && host_lock && !blocked) begin locked = 1; lock_len = 1; end
            end else if (!host_lock) locked = 0;
            else if (lock_len == MAX_LOCK) begin locked = 0; blocked = 1; end
            else lock_len++;
            if (!host_lock) blocked = 0;
        end
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_we = 0; host_req = 0; host_we = 0; host_lock = 0;
        settle();
        advance();
    endtask

    task automatic test_reset();
        rst = 1; cpu_req = 1; cpu_we = 1; host_req = 1; host_we = 1; host_lock = 1;
        cpu_addr = 8'h00; cpu_wdata = 8'h00; host_addr = 8'h00; host_wdata = 8'h00;
        settle();
        n_checks++;
        if ({cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, mem_wr, cpu_rdata, host_rdata} !== 21'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %b want all zero", {cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, mem_wr, cpu_rdata, host_rdata});
        end
        advance();
        settle();
        advance();
        rst = 0;
        idle();
    endtask

    task automatic test_uncontested();
        mem[8'h10] = 8'h5A; ref_mem[8'h10] = 8'h5A;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        settle();
        n_checks++;
        if ({cpu_gnt, host_gnt, cpu_stall, mem_wr, mem_addr} !== {4'b1000, 8'h10}) begin
            n_fail++; $display("FAIL unc_cpu_grant: got %b want %b", {cpu_gnt, host_gnt, cpu_stall, mem_wr, mem_addr}, {4'b1000, 8'h10});
        end
        advance();
        cpu_req = 0;
        settle();
        n_checks++;
        if ({cpu_rvalid, cpu_rdata, host_rvalid} !== {1'b1, 8'h5A, 1'b0}) begin
            n_fail++; $display("FAIL unc_cpu_rdata: got rvalid=%b data=%h hrv=%b want 1 5a 0", cpu_rvalid, cpu_rdata, host_rvalid);
        end
        advance();
        host_req = 1; host_we = 1; host_addr = 8'h20; host_wdata = 8'hC3;
        settle();
        n_checks++;
        if ({host_gnt, cpu_gnt, mem_wr, mem_addr, mem_din} !== {3'b101, 8'h20, 8'hC3}) begin
            n_fail++; $display("FAIL unc_host_write: got %b want %b", {host_gnt, cpu_gnt, mem_wr, mem_addr, mem_din}, {3'b101, 8'h20, 8'hC3});
        end
        advance();
        host_req = 0; host_we = 0; cpu_req = 1; cpu_addr = 8'h20;
        settle();
        n_checks++;
        if ({host_rvalid, cpu_rvalid} !== 2'b00) begin
            n_fail++; $display("FAIL unc_write_no_rvalid: got %b want 00", {host_rvalid, cpu_rvalid});
        end
        advance();
        cpu_req = 0;
        settle();
        n_checks++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'hC3}) begin
            n_fail++; $display("FAIL unc_readback: got %b %h want 1 c3", cpu_rvalid, cpu_rdata);
        end
        advance();
    endtask

    task automatic test_contention();
        bit want_h;
        idle();
        cpu_req = 1; cpu_we = 0; host_req = 1; host_we = 0; host_lock = 0;
        for (int c = 0; c < 10; c++) begin
            cpu_addr = 8'($urandom); host_addr = 8'($urandom);
            want_h = (c % (MAX_WAIT + 1)) == MAX_WAIT;
            settle();
            n_checks++;
            if ({host_gnt, cpu_gnt, cpu_stall} !== {want_h, !want_h, want_h}) begin
                n_fail++; $display("FAIL contention_c%0d: got h/c/stall=%b want %b", c, {host_gnt, cpu_gnt, cpu_stall}, {want_h, !want_h, want_h});
            end
            advance();
        end
        idle();
    endtask

    task automatic test_lock_burst();
        cpu_req = 0; host_req = 1; host_we = 0; host_lock = 1; host_addr = 8'h05;
        settle();
        n_checks++;
        if (host_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_first_grant: got %b want 1", host_gnt); end
        advance();
        cpu_req = 1; cpu_we = 0;
        for (int c = 0; c < 5; c++) begin
            settle();
            n_checks++;
            if ({cpu_gnt, host_gnt, cpu_stall} !== 3'b011) begin
                n_fail++; $display("FAIL lock_hold_c%0d: got c/h/stall=%b want 011", c, {cpu_gnt, host_gnt, cpu_stall});
            end
            advance();
        end
        host_lock = 0; host_req = 0;
        settle();
        n_checks++;
        if (cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_release_cpu: got %b want 1", cpu_gnt); end
        advance();
        idle();
    endtask

    task automatic test_forced_release();
        bit want_h;
        cpu_req = 0; host_req = 1; host_we = 0; host_lock = 1;
        settle();
        advance();
        cpu_req = 1; cpu_we = 0;
        for (int c = 1; c <= MAX_LOCK; c++) begin
            settle();
            n_checks++;
            if ({cpu_gnt, host_gnt} !== 2'b01) begin
                n_fail++; $display("FAIL forced_lock_c%0d: got c/h=%b want 01", c, {cpu_gnt, host_gnt});
            end
            advance();
        end
        for (int c = 0; c < 10; c++) begin
            want_h = (c % (MAX_WAIT + 1)) == MAX_WAIT;
            settle();
            n_checks++;
            if ({host_gnt, cpu_gnt} !== {want_h, !want_h}) begin
                n_fail++; $display("FAIL forced_blocked_c%0d: got h/c=%b want %b", c, {host_gnt, cpu_gnt}, {want_h, !want_h});
            end
            advance();
        end
        host_lock = 0;
        settle();
        advance();
        host_lock = 1; cpu_req = 0;
        settle();
        advance();
        cpu_req = 1;
        settle();
        n_checks++;
        if ({cpu_gnt, host_gnt} !== 2'b01) begin
            n_fail++; $display("FAIL forced_relock: got c/h=%b want 01", {cpu_gnt, host_gnt});
        end
        advance();
        idle();
    endtask

    task automatic test_back_to_back();
        mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h33;
        ref_mem[1] = 8'h11; ref_mem[2] = 8'h22; ref_mem[3] = 8'h33;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h01;
        settle();
        advance();
        cpu_req = 0; host_req = 1; host_we = 0; host_addr = 8'h02;
        settle();
        n_checks++;
        if ({host_gnt, cpu_rvalid, cpu_rdata, host_rvalid, host_rdata} !== {2'b11, 8'h11, 1'b0, 8'h00}) begin
            n_fail++; $display("FAIL b2b_cpu1: got hg=%b crv=%b crd=%h hrv=%b hrd=%h want 1 1 11 0 00", host_gnt, cpu_rvalid, cpu_rdata, host_rvalid, host_rdata);
        end
        advance();
        host_req = 0; cpu_req = 1; cpu_addr = 8'h03;
        settle();
        n_checks++;
        if ({cpu_gnt, cpu_rvalid, cpu_rdata, host_rvalid, host_rdata} !== {2'b10, 8'h00, 1'b1, 8'h22}) begin
            n_fail++; $display("FAIL b2b_host2: got cg=%b crv=%b crd=%h hrv=%b hrd=%h want 1 0 00 1 22", cpu_gnt, cpu_rvalid, cpu_rdata, host_rvalid, host_rdata);
        end
        advance();
        cpu_req = 0;
        settle();
        n_checks++;
        if ({cpu_rvalid, cpu_rdata, host_rvalid, host_rdata} !== {1'b1, 8'h33, 1'b0, 8'h00}) begin
            n_fail++; $display("FAIL b2b_cpu3: got crv=%b crd=%h hrv=%b hrd=%h want 1 33 0 00", cpu_rvalid, cpu_rdata, host_rvalid, host_rdata);
        end
        advance();
    endtask

    task automatic test_reset_mid();
        host_req = 1; host_we = 0; host_addr = 8'h02;
        settle();
        advance();
        host_req = 0; rst = 1;
        settle();
        n_checks++;
        if ({host_rvalid, host_rdata} !== 9'd0) begin
            n_fail++; $display("FAIL rstmid_during: got hrv=%b hrd=%h want 0 00", host_rvalid, host_rdata);
        end
        advance();
        rst = 0;
        settle();
        n_checks++;
        if ({host_rvalid, cpu_rvalid} !== 2'b00) begin
            n_fail++; $display("FAIL rstmid_after: got hrv/crv=%b want 00", {host_rvalid, cpu_rvalid});
        end
        advance();
        cpu_req = 1; cpu_we = 0; host_req = 1; host_lock = 1;
        settle();
        n_checks++;
        if ({cpu_gnt, host_gnt} !== 2'b10) begin
            n_fail++; $display("FAIL rstmid_first_cpu: got c/h=%b want 10", {cpu_gnt, host_gnt});
        end
        advance();
        idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            if (!cpu_req || e_cg) begin
                cpu_req = ($urandom % 4) != 0; cpu_we = $urandom % 2;
                cpu_addr = 8'($urandom % 16); cpu_wdata = 8'($urandom);
            end
            if (!host_req || e_hg) begin
                host_req = ($urandom % 3) != 0; host_we = $urandom % 2;
                host_addr = 8'($urandom % 16); host_wdata = 8'($urandom);
            end
            if ($urandom % 24 == 0) host_lock = !host_lock;
            rst = ($urandom % 400) == 0;
            settle();
            n_checks++;
            if ({cpu_gnt, host_gnt, cpu_stall, mem_wr, mem_addr, mem_din} !== {e_cg, e_hg, cpu_req && !e_cg, e_wr, e_addr, e_din}) begin
                n_fail++; $display("FAIL rand_grant_c%0d: got %b want %b", c, {cpu_gnt, host_gnt, cpu_stall, mem_wr, mem_addr, mem_din}, {e_cg, e_hg, cpu_req && !e_cg, e_wr, e_addr, e_din});
            end
            n_checks++;
            if ({cpu_rvalid, cpu_rdata, host_rvalid, host_rdata} !== {e_cr, e_crd, e_hr, e_hrd}) begin
                n_fail++; $display("FAIL rand_read_c%0d: got %b want %b", c, {cpu_rvalid, cpu_rdata, host_rvalid, host_rdata}, {e_cr, e_crd, e_hr, e_hrd});
            end
            advance();
        end
        rst = 0;
        idle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        waited = 0; lock_len = 0; rd_who = 0; locked = 0; blocked = 0; rd_val = 8'd0;
        test_reset();
        test_uncontested();
        test_contention();
        test_lock_burst();
        test_forced_release();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
